mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  input  1  pipeline clock, all state rising-edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 valid_i  input  1  execute-stage result present this cycle; sampled only while busy_o=0.
REQ-004 ld_i  input  1  op is load (OPCAT_LD); ld_i and st_i never both high.
REQ-005 st_i  input  1  op is store (OPCAT_ST).
REQ-006 size_i  input  3  bit2 = zero-extend load; bits[1:0]: 00 byte, 01 half, 10 word, 11 reserved, treated as word.
REQ-007 alu_result_i  input  32  ALU output: byte address for LD/ST, writeback value otherwise.
REQ-008 st_data_i  input  32  store data, right-aligned.
REQ-009 wb_reg_i  input  5  destination register index.
REQ-010 busy_o  output  1  stall upstream; input ignored while high.
REQ-011 dmem_req_o  output  1  data-memory request, held until dmem_ack_i.
REQ-012 dmem_we_o  output  1  1 = write.
REQ-013 dmem_addr_o  output  32  word address, {alu_result_i[31:2],2'b00}.
REQ-014 dmem_be_o  output  4  byte enables; bit n = byte lane n, little-endian.
REQ-015 dmem_wdata_o  output  32  store data replicated onto the addressed lane(s).
REQ-016 dmem_rdata_i  input  32  read word, valid with dmem_ack_i.
REQ-017 dmem_ack_i  input  1  single-cycle completion strobe.
REQ-018 wb_valid_o  output  1  one-cycle pulse: wb_data_o/wb_reg_o valid.
REQ-019 wb_reg_o  output  5  destination register index.
REQ-020 wb_data_o  output  32  writeback value.
REQ-021 misalign_o  output  1  one-cycle pulse: misaligned access dropped (alignment-check build only).

Function
REQ-022 FSM states IDLE, ACCESS: IDLE+valid_i+(ld_i|st_i) -> ACCESS next cycle; ACCESS+dmem_ack_i -> IDLE.
REQ-023 Non-memory op in IDLE: wb_valid_o=1, wb_data_o=alu_result_i, wb_reg_o=wb_reg_i next cycle; busy_o stays 0 (latency 1).
REQ-024 In ACCESS: dmem_req_o=1 and busy_o=1; addr/be/wdata/we registered at entry and held stable until ack.
REQ-025 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-026 Load completion: on ack cycle, lane extracted, sign- or zero-extended per size_i[2]; wb_valid_o pulses next cycle.
REQ-027 Store completion: no wb_valid_o; IDLE next cycle after ack.
REQ-028 Back-to-back: input offered in the cycle after ack is accepted (busy_o falls in IDLE).
REQ-029 dmem_ack_i outside ACCESS is ignored; ack in the same cycle as request entry is legal (1-cycle memory).
REQ-030 Wait states unbounded; no timeout.

Reset
REQ-031 On rst_n low: state=IDLE; busy_o, dmem_req_o, dmem_we_o, wb_valid_o, misalign_o = 0; all data/address/be/reg outputs = 0.
REQ-032 Reset mid-ACCESS aborts the transaction; a late ack after reset release is ignored.

Configuration
REQ-033 Macro MEM_ACCESS_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is not issued; misalign_o pulses next cycle; no wb_valid_o; stays IDLE.
REQ-034 Macro undefined: misalign_o tied 0; low address bits ignored for word; half uses addr[1].

Structure
REQ-035 Size encodings, FSM state encodings, and lane-select constants belong in the shared instructions include beside the OPCODE/OPCAT definitions.
REQ-036 One sub-module, mem_lane_align (combinational be/wdata generation and load extract/extend), instantiated once.

Verification
REQ-037 ADD result 0x1234 to r3 -> next cycle wb_valid_o=1, wb_data_o=0x1234, wb_reg_o=3, busy_o=0.
REQ-038 LB signed at 0x103, memory word 0x80FF_FF12, ack after 3 waits -> be=0001<<3=1000, wb_data_o=0xFFFF_FF80.
REQ-039 SH 0xBEEF at 0x202 -> dmem_addr_o=0x200, be=1100, wdata=0xBEEF_BEEF, we=1, no wb_valid_o.
REQ-040 LW then ADD offered in the cycle after ack -> both retire; no bubble beyond 1 cycle.
REQ-041 rst_n low during ACCESS, ack arrives 2 cycles after release -> outputs 0, no wb_valid_o.
REQ-042 MEM_ACCESS_ALIGN_CHECK_EN: LW at 0x102 -> dmem_req_o stays 0, misalign_o pulse; undefined: be=1111, addr=0x100.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared instruction definitions: op categories, access size encodings,
// byte-lane select constants and the mem_access FSM state encoding.
package mem_access_pkg;

  typedef enum logic [1:0] {
    OPCAT_ALU = 2'd0,
    OPCAT_LD  = 2'd1,
    OPCAT_ST  = 2'd2
  } opcat_t;

  // size field: bit2 selects zero-extension on loads, bits[1:0] the width
  localparam int         SZ_ZEXT_BIT = 2;
  localparam logic [1:0] SZ_BYTE     = 2'b00;
  localparam logic [1:0] SZ_HALF     = 2'b01;
  localparam logic [1:0] SZ_WORD     = 2'b10;
  localparam logic [1:0] SZ_RSVD     = 2'b11;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic       we;
    logic [2:0] size;
    logic [1:0] addr_lo;
    logic [4:0] reg_idx;
  } meta_t;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] addr_lo);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replicated data and load lane extract with sign/zero extension.
// Purely combinational; no flow control.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  req_size,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  rsp_size,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    be    = BE_WORD;
    wdata = st_data;
    case (req_size[1:0])
      SZ_BYTE: begin
        be    = BE_BYTE << req_addr_lo;
        wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        be    = BE_HALF << {req_addr_lo[1], 1'b0};
        wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // half loads only look at addr[1]; a set addr[0] is ignored here
  assign byte_lane = rdata[{rsp_addr_lo, 3'b000} +: 8];
  assign half_lane = rdata[{rsp_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = rdata;
    case (rsp_size[1:0])
      SZ_BYTE: ld_data = rsp_size[SZ_ZEXT_BIT] ? {24'b0, byte_lane}
                                               : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: ld_data = rsp_size[SZ_ZEXT_BIT] ? {16'b0, half_lane}
                                               : {{16{half_lane[15]}}, half_lane};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Load/store stage, one outstanding access; ALU results retire after 1 cycle, loads 1 cycle after ack.
// busy_o stalls upstream while an access is outstanding; MEM_ACCESS_ALIGN_CHECK_EN drops misaligned half/word ops.
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        ld_i,
  input  logic        st_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] st_data_i,
  input  logic [4:0]  wb_reg_i,
  output logic        busy_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_reg_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o
);

  state_t      state_q, state_d;
  meta_t       meta_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        wb_vld_q;
  logic [4:0]  wb_reg_q;
  logic [31:0] wb_dat_q;
  logic        accept, is_mem, drop, issue, ld_done;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ld_dat_c;

  assign accept  = (state_q == ST_IDLE) && valid_i;
  assign is_mem  = ld_i | st_i;
  assign issue   = accept && is_mem && !drop;
  assign ld_done = (state_q == ST_ACCESS) && dmem_ack_i && !meta_q.we;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic misalign_q;

  assign drop       = accept && is_mem && is_misaligned(size_i[1:0], alu_result_i[1:0]);
  assign misalign_o = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= drop;
  end
`else
  assign drop       = 1'b0;
  assign misalign_o = 1'b0;
`endif

  mem_lane_align u_lane (
    .req_size    (size_i),
    .req_addr_lo (alu_result_i[1:0]),
    .st_data     (st_data_i),
    .be          (be_c),
    .wdata       (wdata_c),
    .rsp_size    (meta_q.size),
    .rsp_addr_lo (meta_q.addr_lo),
    .rdata       (dmem_rdata_i),
    .ld_data     (ld_dat_c)
  );

  always_comb begin
    state_d    = state_q;
    busy_o     = 1'b0;
    dmem_req_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        busy_o     = 1'b1;
        dmem_req_o = 1'b1;
        if (dmem_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      meta_q   <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      wb_vld_q <= 1'b0;
      wb_reg_q <= '0;
      wb_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      wb_vld_q <= 1'b0;
      if (issue) begin
        addr_q  <= {alu_result_i[31:2], 2'b00};
        be_q    <= be_c;
        wdata_q <= wdata_c;
        meta_q  <= '{we: st_i, size: size_i, addr_lo: alu_result_i[1:0], reg_idx: wb_reg_i};
      end
      if (accept && !is_mem) begin
        wb_vld_q <= 1'b1;
        wb_dat_q <= alu_result_i;
        wb_reg_q <= wb_reg_i;
      end
      if (ld_done) begin
        wb_vld_q <= 1'b1;
        wb_dat_q <= ld_dat_c;
        wb_reg_q <= meta_q.reg_idx;
      end
    end
  end

  assign dmem_we_o    = meta_q.we;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign wb_valid_o   = wb_vld_q;
  assign wb_reg_o     = wb_reg_q;
  assign wb_data_o    = wb_dat_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized ops against a memory model.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ld_i, st_i;
  logic [2:0]  size_i;
  logic [31:0] alu_result_i, st_data_i;
  logic [4:0]  wb_reg_i;
  logic        busy_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic        wb_valid_o;
  logic [4:0]  wb_reg_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  // observations captured by the memory responder
  logic        req_seen, req_stable, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        ack_wbv, ack_busy;
  logic [4:0]  ack_wbr;
  logic [31:0] ack_wbd;

  logic [31:0] mem [16];

  mem_access dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ld_i(ld_i), .st_i(st_i),
    .size_i(size_i), .alu_result_i(alu_result_i), .st_data_i(st_data_i),
    .wb_reg_i(wb_reg_i), .busy_o(busy_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .wb_valid_o(wb_valid_o), .wb_reg_o(wb_reg_o), .wb_data_o(wb_data_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] model_be(input logic [2:0] sz, input logic [31:0] a);
    int lane;
    case (sz[1:0])
      2'd0:    begin lane = int'(a[1:0]);     return 4'(1 << lane); end
      2'd1:    begin lane = a[1] ? 2 : 0;     return 4'(3 << lane); end
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] sz, input logic [31:0] d);
    case (sz[1:0])
      2'd0:    return 32'(d[7:0]) * 32'h0101_0101;
      2'd1:    return 32'(d[15:0]) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] v;
    int off;
    case (sz[1:0])
      2'd0: begin
        off = int'(a[1:0]);
        v = (w >> (8 * off)) & 32'hFF;
        if (!sz[2] && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        off = a[1] ? 2 : 0;
        v = (w >> (8 * off)) & 32'hFFFF;
        if (!sz[2] && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // ---------------- drivers (no checking) ----------------
  task automatic issue_op(input logic ld, input logic st, input logic [2:0] sz,
                          input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd);
    valid_i = 1'b1; ld_i = ld; st_i = st; size_i = sz;
    alu_result_i = alu; st_data_i = sd; wb_reg_i = rd;
    @(negedge clk);
    valid_i = 1'b0; ld_i = 1'b0; st_i = 1'b0;
  endtask

  task automatic serve(input int waits, input logic [31:0] rword);
    req_seen = 1'b0; req_stable = 1'b1;
    ack_wbv = 1'b0; ack_busy = 1'b1; ack_wbr = '0; ack_wbd = '0;
    for (int i = 0; i < 20 && !dmem_req_o; i++) @(negedge clk);
    if (dmem_req_o !== 1'b1) return;
    req_seen = 1'b1;
    req_addr = dmem_addr_o; req_be = dmem_be_o; req_wdata = dmem_wdata_o; req_we = dmem_we_o;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (dmem_req_o !== 1'b1 || busy_o !== 1'b1 || dmem_addr_o !== req_addr ||
          dmem_be_o !== req_be || dmem_wdata_o !== req_wdata || dmem_we_o !== req_we)
        req_stable = 1'b0;
    end
    dmem_ack_i = 1'b1; dmem_rdata_i = rword;
    @(negedge clk);
    dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    ack_wbv = wb_valid_o; ack_wbr = wb_reg_o; ack_wbd = wb_data_o; ack_busy = busy_o;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; valid_i = 0; ld_i = 0; st_i = 0; size_i = 0;
    alu_result_i = 0; st_data_i = 0; wb_reg_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_o, dmem_req_o, dmem_we_o, wb_valid_o, misalign_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {busy_o, dmem_req_o, dmem_we_o, wb_valid_o, misalign_o});
    end
    checks++;
    if ({dmem_addr_o, dmem_be_o, dmem_wdata_o, wb_data_o, wb_reg_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h be=%b wdata=%h wbd=%h wbr=%0d expected all zero",
               dmem_addr_o, dmem_be_o, dmem_wdata_o, wb_data_o, wb_reg_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu_passthrough();
    issue_op(1'b0, 1'b0, 3'b010, 32'h0000_1234, 32'h0, 5'd3);
    checks++;
    if ({wb_valid_o, wb_reg_o, wb_data_o, busy_o} !== {1'b1, 5'd3, 32'h0000_1234, 1'b0}) begin
      errors++;
      $display("FAIL add_wb: got v=%b r=%0d d=%h busy=%b expected v=1 r=3 d=00001234 busy=0",
               wb_valid_o, wb_reg_o, wb_data_o, busy_o);
    end
    @(negedge clk);
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL add_pulse: wb_valid_o=%b expected 0 one cycle later", wb_valid_o);
    end
  endtask

  task automatic test_lb_signed();
    issue_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd5);
    serve(3, 32'h80FF_FF12);
    checks++;
    if ({req_seen, req_stable, req_we, req_addr, req_be} !== {1'b1, 1'b1, 1'b0, 32'h100, 4'b1000}) begin
      errors++;
      $display("FAIL lb_req: seen=%b stable=%b we=%b addr=%h be=%b expected 1 1 0 00000100 1000",
               req_seen, req_stable, req_we, req_addr, req_be);
    end
    checks++;
    if ({ack_wbv, ack_wbr, ack_wbd, ack_busy} !== {1'b1, 5'd5, 32'hFFFF_FF80, 1'b0}) begin
      errors++;
      $display("FAIL lb_wb: v=%b r=%0d d=%h busy=%b expected 1 5 ffffff80 0",
               ack_wbv, ack_wbr, ack_wbd, ack_busy);
    end
  endtask

  task automatic test_sh();
    issue_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 5'd7);
    serve(1, 32'h1357_9BDF);
    checks++;
    if ({req_seen, req_stable, req_we, req_addr, req_be, req_wdata} !==
        {1'b1, 1'b1, 1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF}) begin
      errors++;
      $display("FAIL sh_req: seen=%b stable=%b we=%b addr=%h be=%b wdata=%h expected 1 1 1 00000200 1100 beefbeef",
               req_seen, req_stable, req_we, req_addr, req_be, req_wdata);
    end
    checks++;
    if ({ack_wbv, ack_busy} !== 2'b00) begin
      errors++;
      $display("FAIL sh_no_wb: wb_valid=%b busy=%b expected 0 0", ack_wbv, ack_busy);
    end
    @(negedge clk);
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL sh_no_wb_late: wb_valid_o=%b expected 0", wb_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    issue_op(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 5'd8);
    serve(0, 32'hCAFE_F00D);
    checks++;
    if ({ack_wbv, ack_wbr, ack_wbd, ack_busy} !== {1'b1, 5'd8, 32'hCAFE_F00D, 1'b0}) begin
      errors++;
      $display("FAIL b2b_lw: v=%b r=%0d d=%h busy=%b expected 1 8 cafef00d 0",
               ack_wbv, ack_wbr, ack_wbd, ack_busy);
    end
    issue_op(1'b0, 1'b0, 3'b010, 32'h0000_0055, 32'h0, 5'd9);
    checks++;
    if ({wb_valid_o, wb_reg_o, wb_data_o} !== {1'b1, 5'd9, 32'h55}) begin
      errors++;
      $display("FAIL b2b_add: v=%b r=%0d d=%h expected 1 9 00000055",
               wb_valid_o, wb_reg_o, wb_data_o);
    end
  endtask

  task automatic test_reset_mid_access();
    int pulses = 0;
    issue_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd4);
    checks++;
    if (dmem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_req: dmem_req_o=%b expected 1", dmem_req_o);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_o, dmem_req_o, dmem_we_o, wb_valid_o, dmem_addr_o, dmem_be_o, dmem_wdata_o} !== '0) begin
      errors++;
      $display("FAIL rst_mid_out: busy=%b req=%b we=%b wbv=%b addr=%h be=%b wdata=%h expected all zero",
               busy_o, dmem_req_o, dmem_we_o, wb_valid_o, dmem_addr_o, dmem_be_o, dmem_wdata_o);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    for (int i = 0; i < 4; i++) begin
      if (wb_valid_o === 1'b1 || dmem_req_o === 1'b1 || busy_o === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL rst_late_ack: %0d cycles with wb_valid/req/busy set, expected 0", pulses);
    end
  endtask

  task automatic test_word_misalign();
    issue_op(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 5'd6);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    checks++;
    if ({misalign_o, dmem_req_o, wb_valid_o, busy_o} !== 4'b1000) begin
      errors++;
      $display("FAIL lw_misalign: mis=%b req=%b wbv=%b busy=%b expected 1 0 0 0",
               misalign_o, dmem_req_o, wb_valid_o, busy_o);
    end
    @(negedge clk);
    checks++;
    if ({misalign_o, dmem_req_o, wb_valid_o} !== 3'b000) begin
      errors++;
      $display("FAIL lw_misalign_pulse: mis=%b req=%b wbv=%b expected 0 0 0",
               misalign_o, dmem_req_o, wb_valid_o);
    end
`else
    checks++;
    if (misalign_o !== 1'b0) begin
      errors++;
      $display("FAIL lw_no_misalign: misalign_o=%b expected 0", misalign_o);
    end
    serve(0, 32'h0BAD_F00D);
    checks++;
    if ({req_seen, req_addr, req_be, ack_wbv, ack_wbd} !==
        {1'b1, 32'h100, 4'b1111, 1'b1, 32'h0BAD_F00D}) begin
      errors++;
      $display("FAIL lw_lowbits: seen=%b addr=%h be=%b wbv=%b d=%h expected 1 00000100 1111 1 0badf00d",
               req_seen, req_addr, req_be, ack_wbv, ack_wbd);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a, sd, alu, exp_w, exp_d;
    logic [3:0]  exp_b, idx;
    logic [2:0]  sz;
    logic [4:0]  rd;
    int          kind, waits;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int n = 0; n < 80; n++) begin
      kind  = $urandom_range(0, 2);
      sz    = 3'($urandom_range(0, 7));
      rd    = 5'($urandom_range(0, 31));
      sd    = $urandom;
      alu   = $urandom;
      waits = $urandom_range(0, 3);
      a     = 32'h1000 + 32'($urandom_range(0, 63));
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      if (sz[1:0] == 2'd1) a = a & ~32'd1;
      else if (sz[1:0] != 2'd0) a = a & ~32'd3;
`endif
      idx = a[5:2];
      if (kind == 0) begin
        issue_op(1'b0, 1'b0, sz, alu, sd, rd);
        checks++;
        if ({wb_valid_o, wb_reg_o, wb_data_o, busy_o} !== {1'b1, rd, alu, 1'b0}) begin
          errors++;
          $display("FAIL rnd_alu[%0d]: v=%b r=%0d d=%h busy=%b expected 1 %0d %h 0",
                   n, wb_valid_o, wb_reg_o, wb_data_o, busy_o, rd, alu);
        end
      end else if (kind == 1) begin
        exp_b = model_be(sz, a);
        exp_d = model_load(sz, a, mem[idx]);
        issue_op(1'b1, 1'b0, sz, a, sd, rd);
        serve(waits, mem[idx]);
        checks++;
        if ({req_seen, req_stable, req_we, req_addr, req_be} !==
            {1'b1, 1'b1, 1'b0, a & ~32'd3, exp_b}) begin
          errors++;
          $display("FAIL rnd_ld_req[%0d]: seen=%b stable=%b we=%b addr=%h be=%b expected 1 1 0 %h %b",
                   n, req_seen, req_stable, req_we, req_addr, req_be, a & ~32'd3, exp_b);
        end
        checks++;
        if ({ack_wbv, ack_wbr, ack_wbd} !== {1'b1, rd, exp_d}) begin
          errors++;
          $display("FAIL rnd_ld_wb[%0d]: v=%b r=%0d d=%h expected 1 %0d %h (size %b addr %h)",
                   n, ack_wbv, ack_wbr, ack_wbd, rd, exp_d, sz, a);
        end
      end else begin
        exp_b = model_be(sz, a);
        exp_w = model_wdata(sz, sd);
        issue_op(1'b0, 1'b1, sz, a, sd, rd);
        serve(waits, $urandom);
        checks++;
        if ({req_seen, req_stable, req_we, req_addr, req_be, req_wdata, ack_wbv} !==
            {1'b1, 1'b1, 1'b1, a & ~32'd3, exp_b, exp_w, 1'b0}) begin
          errors++;
          $display("FAIL rnd_st[%0d]: seen=%b stable=%b we=%b addr=%h be=%b wdata=%h wbv=%b expected 1 1 1 %h %b %h 0",
                   n, req_seen, req_stable, req_we, req_addr, req_be, req_wdata, ack_wbv,
                   a & ~32'd3, exp_b, exp_w);
        end
        for (int b = 0; b < 4; b++)
          if (exp_b[b]) mem[idx][8*b +: 8] = exp_w[8*b +: 8];
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_passthrough();
    test_lb_signed();
    test_sh();
    test_back_to_back();
    test_reset_mid_access();
    test_word_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
